// File: rtl/delay_token_bank.sv
// Per-channel token bank: captures mature after DELAY cycles, then wait in a saturating counter until released.
// out is combinational with the same-cycle release; there is no backpressure, a refused release only sets the sticky underflow flag.
module delay_token_bank #(
    parameter int CHANNELS = 4,
    parameter int COUNT_W  = 8,
    parameter int DELAY    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clear,
    input  logic [CHANNELS-1:0]         i_capture,
    input  logic [CHANNELS-1:0]         i_release,
    output logic [CHANNELS-1:0]         o_out,
    output logic [CHANNELS*COUNT_W-1:0] o_ready_count,
    output logic [CHANNELS-1:0]         o_empty,
    output logic [CHANNELS-1:0]         o_overflow,
    output logic [CHANNELS-1:0]         o_underflow
);
    localparam int SR_W = (DELAY > 0) ? DELAY : 1;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            logic [COUNT_W-1:0] r_count;
            logic               r_ovf;
            logic               r_unf;
            logic               w_arrive;
            logic               w_inflight;
            logic               w_out;

            if (DELAY == 0) begin : g_bypass
                assign w_arrive   = i_capture[g];
                assign w_inflight = 1'b0;
            end else begin : g_delay
                logic [SR_W-1:0] r_sr;

                // A capture in a clear cycle is dropped along with everything in flight.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_sr <= '0;
                    end else if (i_clear) begin
                        r_sr <= '0;
                    end else begin
                        r_sr <= (r_sr << 1) | SR_W'(i_capture[g]);
                    end
                end

                assign w_arrive   = r_sr[SR_W-1];
                assign w_inflight = |r_sr;
            end

            assign w_out = i_release[g] && ((r_count != '0) || w_arrive) && !i_clear;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                    r_unf   <= 1'b0;
                end else if (i_clear) begin
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                    r_unf   <= 1'b0;
                end else begin
                    // arrive together with out passes straight through and leaves the count alone.
                    if (w_arrive && !w_out) begin
                        if (r_count == CNT_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_ONE;
                        end
                    end else if (!w_arrive && w_out) begin
                        r_count <= r_count - CNT_ONE;
                    end
                    if (i_release[g] && !w_out) begin
                        r_unf <= 1'b1;
                    end
                end
            end

            assign o_out[g]                             = w_out;
            assign o_ready_count[g*COUNT_W +: COUNT_W]  = r_count;
            assign o_empty[g]                           = (r_count == '0) && !w_inflight;
            assign o_overflow[g]                        = r_ovf;
            assign o_underflow[g]                       = r_unf;
        end
    endgenerate
endmodule

// File: tb/tb_delay_token_bank.sv
// Three delay_token_bank configurations driven by directed and random stimulus, checked against a queue-based token model.
module tb_delay_token_bank;
    localparam int NI = 3;
    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr   [NI];
    logic [NC-1:0]   cap   [NI];
    logic [NC-1:0]   rel   [NI];
    logic [NC-1:0]   out_a [NI];
    logic [NC-1:0]   emp_a [NI];
    logic [NC-1:0]   ovf_a [NI];
    logic [NC-1:0]   unf_a [NI];
    logic [4*3-1:0]  rc0;
    logic [4*8-1:0]  rc1;
    logic [4*4-1:0]  rc2;

    int total = 0;
    int bad   = 0;

    int m_cnt [NI][NC];
    bit m_ovf [NI][NC];
    bit m_unf [NI][NC];
    int m_q   [NI][NC][$];
    int cyc = 0;

    always #5 clk = ~clk;

    delay_token_bank #(.CHANNELS(4), .COUNT_W(3), .DELAY(0)) u_d0 (
        .clk(clk), .rst(rst), .i_clear(clr[0]), .i_capture(cap[0]), .i_release(rel[0]),
        .o_out(out_a[0]), .o_ready_count(rc0), .o_empty(emp_a[0]),
        .o_overflow(ovf_a[0]), .o_underflow(unf_a[0]));

    delay_token_bank #(.CHANNELS(4), .COUNT_W(8), .DELAY(5)) u_d5 (
        .clk(clk), .rst(rst), .i_clear(clr[1]), .i_capture(cap[1]), .i_release(rel[1]),
        .o_out(out_a[1]), .o_ready_count(rc1), .o_empty(emp_a[1]),
        .o_overflow(ovf_a[1]), .o_underflow(unf_a[1]));

    delay_token_bank #(.CHANNELS(4), .COUNT_W(4), .DELAY(4)) u_d4 (
        .clk(clk), .rst(rst), .i_clear(clr[2]), .i_capture(cap[2]), .i_release(rel[2]),
        .o_out(out_a[2]), .o_ready_count(rc2), .o_empty(emp_a[2]),
        .o_overflow(ovf_a[2]), .o_underflow(unf_a[2]));

    function automatic int dly(int i);
        return (i == 0) ? 0 : ((i == 1) ? 5 : 4);
    endfunction

    function automatic int wid(int i);
        return (i == 0) ? 3 : ((i == 1) ? 8 : 4);
    endfunction

    function automatic int rcv(int i, int c);
        if (i == 0) return int'(rc0[c*3 +: 3]);
        if (i == 1) return int'(rc1[c*8 +: 8]);
        return int'(rc2[c*4 +: 4]);
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Token model: a pending token is just its maturity cycle; matured tokens are a plain integer count.
    always @(negedge clk) begin
        bit arr;
        bit o;
        int mx;
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < NC; c++) begin
                if (rst) begin
                    m_cnt[i][c] = 0;
                    m_ovf[i][c] = 1'b0;
                    m_unf[i][c] = 1'b0;
                    m_q[i][c].delete();
                    check($sformatf("rst i%0d c%0d count", i, c), rcv(i, c), 0);
                    check($sformatf("rst i%0d c%0d empty", i, c), int'(emp_a[i][c]), 1);
                    check($sformatf("rst i%0d c%0d flags", i, c), int'({ovf_a[i][c], unf_a[i][c]}), 0);
                end else begin
                    mx  = (1 << wid(i)) - 1;
                    arr = (dly(i) == 0) ? cap[i][c]
                                        : (m_q[i][c].size() > 0 && m_q[i][c][0] == cyc);
                    o   = rel[i][c] && (m_cnt[i][c] > 0 || arr) && !clr[i];
                    check($sformatf("i%0d c%0d out", i, c), int'(out_a[i][c]), int'(o));
                    check($sformatf("i%0d c%0d count", i, c), rcv(i, c), m_cnt[i][c]);
                    check($sformatf("i%0d c%0d empty", i, c), int'(emp_a[i][c]),
                          int'(m_cnt[i][c] == 0 && m_q[i][c].size() == 0));
                    check($sformatf("i%0d c%0d overflow", i, c), int'(ovf_a[i][c]), int'(m_ovf[i][c]));
                    check($sformatf("i%0d c%0d underflow", i, c), int'(unf_a[i][c]), int'(m_unf[i][c]));
                    if (clr[i]) begin
                        m_cnt[i][c] = 0;
                        m_ovf[i][c] = 1'b0;
                        m_unf[i][c] = 1'b0;
                        m_q[i][c].delete();
                    end else begin
                        if (arr && dly(i) > 0) void'(m_q[i][c].pop_front());
                        if (arr && !o) begin
                            if (m_cnt[i][c] == mx) m_ovf[i][c] = 1'b1;
                            else m_cnt[i][c]++;
                        end else if (!arr && o) begin
                            m_cnt[i][c]--;
                        end
                        if (rel[i][c] && !o) m_unf[i][c] = 1'b1;
                        if (cap[i][c] && dly(i) > 0) m_q[i][c].push_back(cyc + dly(i));
                    end
                end
            end
        end
        if (!rst) cyc++;
    end

    task automatic idle_all();
        for (int j = 0; j < NI; j++) begin
            clr[j] = 1'b0;
            cap[j] = '0;
            rel[j] = '0;
        end
    endtask

    // One cycle on instance i; returns at posedge+4 so outputs of that cycle can be checked.
    task automatic drive(int i, logic cl, logic [NC-1:0] cp, logic [NC-1:0] rl);
        @(posedge clk);
        #1;
        idle_all();
        clr[i] = cl;
        cap[i] = cp;
        rel[i] = rl;
        #3;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Bypass at DELAY=0, channel 0.
        drive(0, 1'b0, 4'b0001, 4'b0001);
        check("byp same-cycle out", int'(out_a[0][0]), 1);
        check("byp same-cycle count", rcv(0, 0), 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b0, 4'b0001, 4'b0000);
            check("byp capture count", rcv(0, 0), k);
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b0, 4'b0000, 4'b0001);
            check("byp release out", int'(out_a[0][0]), (k < 3) ? 1 : 0);
            check("byp release count", rcv(0, 0), 3 - k);
        end
        drive(0, 1'b0, 4'b0000, 4'b0000);
        check("byp underflow", int'(unf_a[0][0]), 1);
        check("byp final count", rcv(0, 0), 0);

        // Saturation at COUNT_W=3, channel 1.
        for (int k = 0; k < 9; k++) begin
            drive(0, 1'b0, 4'b0010, 4'b0000);
            check("sat count", rcv(0, 1), (k > 7) ? 7 : k);
            check("sat overflow", int'(ovf_a[0][1]), (k >= 8) ? 1 : 0);
        end
        for (int k = 0; k < 7; k++) begin
            drive(0, 1'b0, 4'b0000, 4'b0010);
            check("sat release out", int'(out_a[0][1]), 1);
            check("sat release count", rcv(0, 1), 7 - k);
        end
        drive(0, 1'b0, 4'b0000, 4'b0000);
        check("sat drained count", rcv(0, 1), 0);
        check("sat overflow sticky", int'(ovf_a[0][1]), 1);

        // Latency at DELAY=5, channel 1: release held from 8, capture at 10.
        for (int c = 8; c <= 16; c++) begin
            drive(1, 1'b0, (c == 10) ? 4'b0010 : 4'b0000, 4'b0010);
            check($sformatf("lat out cyc%0d", c), int'(out_a[1][1]), (c == 15) ? 1 : 0);
            check($sformatf("lat underflow cyc%0d", c), int'(unf_a[1][1]), (c >= 9) ? 1 : 0);
            check($sformatf("lat empty cyc%0d", c), int'(emp_a[1][1]), (c >= 11 && c <= 15) ? 0 : 1);
        end

        // Flush at DELAY=4, channel 2.
        drive(2, 1'b0, 4'b0100, 4'b0000);
        check("flush c0 empty", int'(emp_a[2][2]), 1);
        drive(2, 1'b0, 4'b0100, 4'b0000);
        check("flush c1 empty", int'(emp_a[2][2]), 0);
        check("flush c1 count", rcv(2, 2), 0);
        drive(2, 1'b1, 4'b0000, 4'b0000);
        check("flush c2 empty", int'(emp_a[2][2]), 0);
        for (int c = 3; c <= 6; c++) begin
            drive(2, 1'b0, 4'b0000, 4'b0100);
            check($sformatf("flush out cyc%0d", c), int'(out_a[2][2]), 0);
            check($sformatf("flush count cyc%0d", c), rcv(2, 2), 0);
            check($sformatf("flush empty cyc%0d", c), int'(emp_a[2][2]), 1);
            if (c == 3) check("flush flags", int'({ovf_a[2][2], unf_a[2][2]}), 0);
        end

        // Async reset with five matured tokens on instance 1 channel 3.
        for (int k = 0; k < 5; k++) drive(1, 1'b0, 4'b1000, 4'b0000);
        for (int k = 0; k < 6; k++) drive(1, 1'b0, 4'b0000, 4'b0000);
        check("arst pre count", rcv(1, 3), 5);
        check("arst pre empty", int'(emp_a[1][3]), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst count", rcv(1, 3), 0);
        check("arst empty", int'(emp_a[1][3]), 1);
        check("arst underflow", int'(unf_a[0][0]), 0);
        check("arst overflow", int'(ovf_a[0][1]), 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Random traffic on every channel of every instance, bias alternating every 1000 cycles.
        for (int n = 0; n < 10000; n++) begin
            int pc;
            int pr;
            @(posedge clk);
            #1;
            pc = ((n / 1000) % 2 == 0) ? 70 : 30;
            pr = 100 - pc;
            for (int i = 0; i < NI; i++) begin
                clr[i] = ($urandom_range(0, 299) == 0);
                for (int c = 0; c < NC; c++) begin
                    cap[i][c] = ($urandom_range(0, 99) < pc);
                    rel[i][c] = ($urandom_range(0, 99) < pr);
                end
            end
        end
        @(posedge clk);
        #1;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/delay_token_bank.md
Name: delay_token_bank

Overview:
- Multi-channel, parametrised successor to the single-channel capture/release delay counter.
- Each channel tracks tokens (capture pulses) that must later be released to downstream logic.
- Adds configurable minimum latency, counter saturation, sticky error flags and synchronous flush.
- Sits between an upstream stage that emits valid strobes and a downstream stage that consumes them later, e.g. to align kernel-result valids with a variable-latency datapath.

Parameters:
- CHANNELS, 4: number of independent channels, >=1.
- COUNT_W, 8: width of each channel's ready-token counter; saturates at 2^COUNT_W-1.
- DELAY, 0: minimum cycles between a capture and the earliest release it can satisfy, 0..64. At 0 the same-cycle capture+release bypass applies.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous flush of all channels.
- capture  in  CHANNELS  per-channel token-in strobe.
- release  in  CHANNELS  per-channel token-out request.
- out  out  CHANNELS  per-channel release granted this cycle (combinational).
- ready_count  out  CHANNELS*COUNT_W  per-channel matured-token count; channel i occupies bits [i*COUNT_W +: COUNT_W].
- empty  out  CHANNELS  ready_count==0 and no token in flight for that channel.
- overflow  out  CHANNELS  sticky: a matured token was dropped at saturation.
- underflow  out  CHANNELS  sticky: release requested with no token available.

Behaviour:
- Reset (rst=1, async): all counters, in-flight shift registers and sticky flags go to 0; empty=all 1s; out=0 once rst is deasserted with release low.
- Per channel i, arrive[i]:
  - DELAY=0: arrive = capture[i].
  - DELAY>=1: arrive = bit DELAY-1 of a DELAY-bit shift register. capture[i] shifts into bit 0 each cycle.
  - A capture at cycle t therefore produces arrive at cycle t+DELAY.
- out[i] = release[i] && (ready_count[i]>0 || arrive[i]) && !clear. Purely combinational, no added latency.
- Counter update per cycle, priority order:
  1. clear: count<=0, shift register<=0, overflow<=0, underflow<=0.
  2. arrive && out: hold. The token passes straight through.
  3. arrive && !out: count+1. If count==max, hold and set overflow.
  4. !arrive && out: count-1. out guarantees count>0.
  5. Otherwise: hold.
- Underflow: release[i] && !out[i] && !clear sets underflow[i]. The counter never wraps below 0.
- Overflow/underflow stay set until clear or rst. They do not affect token flow.
- empty[i] = (ready_count[i]==0) && (shift register[i]==0).
- Channels are fully independent; simultaneous events on different channels never interact.
- clear mid-flight discards in-flight captures: no arrive is produced for any capture made at or before the clear cycle.
- A capture in the same cycle as clear is also discarded.
- rst asserted mid-operation behaves the same as clear but takes effect asynchronously.
- Arithmetic: all counts are unsigned COUNT_W-bit values. The saturation check compares against all-ones; no modular wrap ever occurs.

Test Plan:
- Bypass, DELAY=0, ch0: capture=1, release=1 in the same cycle -> out[0]=1, ready_count[0] stays 0. Capture alone for 3 cycles, then release alone for 4 cycles -> out[0]=1,1,1,0; ready_count 3->0; underflow[0]=1 after cycle 4.
- Latency, DELAY=5: capture ch1 at cycle 10, release held high from cycle 8 -> out[1]=0 in cycles 8-14, out[1]=1 at cycle 15 only. underflow[1]=1 from cycle 9 (set by the cycle-8 request); empty[1]=0 during cycles 11-15.
- Saturation, COUNT_W=3, DELAY=0: 9 captures with no release -> ready_count=7 after the 7th, overflow=1 after the 8th, count still 7. Then 7 releases -> out high 7 cycles, count 0, overflow still 1.
- Flush, DELAY=4: capture ch2 at cycles 0 and 1 (ready_count stays 0 until the captures mature at cycles 4-5); assert clear at cycle 2 -> no arrive at cycles 4-5, out[2]=0 on release, ready_count=0, empty=1, flags 0.
- Async reset mid-operation: ready_count=5 on ch3, assert rst between edges -> ready_count, flags and shift registers are 0 immediately; empty=1 without a clock edge.
- Channel independence, CHANNELS=4: random capture/release on all channels for 10k cycles against a per-channel reference model -> out, ready_count and flags match every cycle.
